a1335_i2c_responder: RTL and testbench

- I2C target (slave) that emulates the A1335 angle sensor on the shared sda/scl bus.
- Answers the read-angle and status transactions that the myo_control I2C master issues.
- Used in simulation and in loopback bring-up as a stand-in for a real sensor.
- Serves a small byte-addressed register window built from live angle and status inputs, with an auto-incrementing register pointer.

---
 rtl/a1335_i2c_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_a1335_i2c_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a1335_i2c_responder.sv
// a1335_i2c_responder: I2C target emulating the A1335 angle sensor.
// Serves a read-only register window (angle at REG_ANGLE, status at
// REG_STATUS) with an auto-incrementing register pointer.
// Optional clock stretching after a read-address ACK: define
// A1335_RESP_STRETCH_EN.
`timescale 1ns/1ps

module a1335_i2c_responder #(
   parameter int unsigned FILTER_LEN     = 3,
   parameter logic [7:0]  REG_ANGLE      = 8'h20,
   parameter logic [7:0]  REG_STATUS     = 8'h24,
   parameter int unsigned STRETCH_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic        scl_oe,
   input  logic [6:0]  device_id,
   input  logic [11:0] angle,
   input  logic [31:0] status,
   output logic        busy,
   output logic [7:0]  reg_ptr,
   output logic        rd_done
);

   localparam int FILT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
   } state_t;

   state_t            state;
   logic [1:0]        scl_sync, sda_sync;
   logic              scl_f, sda_f, scl_prev, sda_prev;
   logic [FILT_W-1:0] scl_cnt, sda_cnt;
   logic              scl_rise, scl_fall, start_det, stop_det;
   logic [3:0]        bit_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift, shift_next, rd_data;
   logic              rw, first_wr;
   logic              addr_done, addr_match, snap_en;
   logic [11:0]       angle_snap;
   logic [31:0]       status_snap;

   // Synchronise both pins, reject pulses shorter than FILTER_LEN samples, keep previous level for edges
   always_ff @(posedge clock) begin
      // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
      if (!reset_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
         scl_cnt  <= '0;
         sda_cnt  <= '0;
      end else begin
         scl_sync <= {scl_sync[0], scl_in};
         sda_sync <= {sda_sync[0], sda_in};
         scl_prev <= scl_f;
         sda_prev <= sda_f;
         if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
         end else if (scl_cnt == FILT_W'(FILTER_LEN - 1)) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 1'b1;
         end
         if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
         end else if (sda_cnt == FILT_W'(FILTER_LEN - 1)) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 1'b1;
         end
      end
   end

   assign scl_rise   = scl_f & ~scl_prev;
   assign scl_fall   = ~scl_f & scl_prev;
   assign start_det  = ~sda_f & sda_prev & scl_f;
   assign stop_det   = sda_f & ~sda_prev & scl_f;
   assign shift_next = {shift[6:0], sda_f};
   assign bit_idx    = 3'd7 - bit_cnt[2:0];
   assign addr_done  = (state == S_ADDR) && scl_rise && (bit_cnt == 4'd7) && !start_det && !stop_det;
   assign addr_match = (shift_next[7:1] == device_id) && (shift_next[7:1] != 7'd0);
   assign snap_en    = addr_done && addr_match && shift_next[0];

   // Freeze angle and status when a read address matches so multi-byte reads are coherent
   always_ff @(posedge clock) begin
      // NOTE: snapshot registers carry no reset; they are always loaded before any read can reach them.
      if (snap_en) begin
         angle_snap  <= angle;
         status_snap <= status;
      end
   end

   // Register window decode for the byte at reg_ptr
   always_comb begin
      // NOTE: default assigned first so no path leaves rd_data unassigned (no latch).
      rd_data = 8'h00;
      if (reg_ptr == REG_ANGLE)                rd_data = {4'b0000, angle_snap[11:8]};
      else if (reg_ptr == REG_ANGLE + 8'd1)    rd_data = angle_snap[7:0];
      else if (reg_ptr == REG_STATUS)          rd_data = status_snap[31:24];
      else if (reg_ptr == REG_STATUS + 8'd1)   rd_data = status_snap[23:16];
      else if (reg_ptr == REG_STATUS + 8'd2)   rd_data = status_snap[15:8];
      else if (reg_ptr == REG_STATUS + 8'd3)   rd_data = status_snap[7:0];
   end

   // Protocol FSM: bus conditions first, then per-state bit handling on filtered SCL edges
   always_ff @(posedge clock) begin
      rd_done <= 1'b0;
      if (!reset_n) begin
         state    <= S_IDLE;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         reg_ptr  <= 8'h00;
         bit_cnt  <= 4'd0;
         shift    <= 8'h00;
         rw       <= 1'b0;
         first_wr <= 1'b0;
      end else if (start_det) begin
         state   <= S_ADDR;
         bit_cnt <= 4'd0;
         sda_oe  <= 1'b0;
      end else if (stop_det) begin
         state   <= S_IDLE;
         bit_cnt <= 4'd0;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_IGNORE: ;
            S_ADDR: if (scl_rise) begin
               shift   <= shift_next;
               bit_cnt <= bit_cnt + 4'd1;
               if (addr_done) begin
                  bit_cnt <= 4'd0;
                  if (addr_match) begin
                     state    <= S_ADDR_ACK;
                     rw       <= shift_next[0];
                     first_wr <= ~shift_next[0];
                     busy     <= 1'b1;
                  end else begin
                     state <= S_IGNORE;
                  end
               end
            end
            S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
               if (bit_cnt == 4'd0) begin
                  sda_oe  <= 1'b1;
                  bit_cnt <= 4'd1;
               end else begin
                  bit_cnt <= 4'd0;
                  if (state == S_ADDR_ACK && rw) begin
                     sda_oe <= ~rd_data[7];
                     state  <= S_RD_BYTE;
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= S_WR_BYTE;
                  end
               end
            end
            S_WR_BYTE: if (scl_rise) begin
               shift   <= shift_next;
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  bit_cnt <= 4'd0;
                  state   <= S_WR_ACK;
                  if (first_wr) begin
                     reg_ptr  <= shift_next;
                     first_wr <= 1'b0;
                  end
               end
            end
            S_RD_BYTE: begin
               if (scl_rise) begin
                  bit_cnt <= bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= S_RD_ACK;
                  end else begin
                     sda_oe <= ~rd_data[bit_idx];
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise && bit_cnt == 4'd0) begin
                  rd_done <= 1'b1;
                  reg_ptr <= reg_ptr + 8'd1;
                  if (sda_f) state   <= S_IGNORE;
                  else       bit_cnt <= 4'd1;
               end else if (scl_fall && bit_cnt == 4'd1) begin
                  bit_cnt <= 4'd0;
                  sda_oe  <= ~rd_data[7];
                  state   <= S_RD_BYTE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef A1335_RESP_STRETCH_EN
   localparam int STR_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
   logic [STR_W-1:0] stretch_cnt;
   logic             stretch_go;

   assign stretch_go = (state == S_ADDR_ACK) && rw && scl_fall && (bit_cnt == 4'd1) &&
                       !start_det && !stop_det;

   // Hold SCL low for STRETCH_CYCLES clocks after a read-address ACK; STOP or reset aborts
   always_ff @(posedge clock) begin
      if (!reset_n || stop_det) begin
         scl_oe      <= 1'b0;
         stretch_cnt <= '0;
      end else if (stretch_go) begin
         scl_oe      <= 1'b1;
         stretch_cnt <= STR_W'(STRETCH_CYCLES - 1);
      end else if (scl_oe) begin
         if (stretch_cnt == '0) scl_oe <= 1'b0;
         else                   stretch_cnt <= stretch_cnt - 1'b1;
      end
   end
`else
   assign scl_oe = 1'b0;
`endif

endmodule

// File: tb/tb_a1335_i2c_responder.sv
// Directed bench for a1335_i2c_responder: drives an open-drain I2C master
// model and checks ACKs, read data, pointer, busy, rd_done and scl_oe.
`timescale 1ns/1ps

module tb_a1335_i2c_responder;

   localparam int H = 10;   // clocks per SCL half period
   localparam int Q = 3;    // clocks from SCL fall to SDA change

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        scl_in, sda_in, sda_oe, scl_oe, busy, rd_done;
   logic [6:0]  device_id = 7'h0C;
   logic [11:0] angle = 12'h000;
   logic [31:0] status = 32'h0;
   logic [7:0]  reg_ptr;

   int n_vec = 0;
   int n_err = 0;
   int rd_done_cnt = 0;
   int scl_oe_cycles = 0;
   int sda_oe_cycles = 0;

   always #5 clock = ~clock;

   assign scl_in = scl_m & ~scl_oe;
   assign sda_in = sda_m & ~sda_oe;

   a1335_i2c_responder dut (
      .clock(clock), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in),
      .sda_oe(sda_oe), .scl_oe(scl_oe), .device_id(device_id), .angle(angle),
      .status(status), .busy(busy), .reg_ptr(reg_ptr), .rd_done(rd_done)
   );

   // free-running event counters; tests take differences
   always @(posedge clock) begin
      if (rd_done) rd_done_cnt   <= rd_done_cnt + 1;
      if (scl_oe)  scl_oe_cycles <= scl_oe_cycles + 1;
      if (sda_oe)  sda_oe_cycles <= sda_oe_cycles + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic scl_high();
      int t;
      scl_m = 1'b1;
      t = 0;
      while (scl_in !== 1'b1 && t < 400) begin
         @(negedge clock);
         t++;
      end
      if (scl_in !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL scl_release: scl_in=%b required 1", scl_in);
      end
   endtask

   task automatic send_bit(input logic b, output logic s);
      wait_clk(Q);
      sda_m = b;
      wait_clk(H);
      scl_high();
      wait_clk(H);
      s = sda_in;
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(H);
      scl_high();
      wait_clk(H);
      sda_m = 1'b0;
      wait_clk(H);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(Q);
      sda_m = 1'b0;
      wait_clk(H);
      scl_high();
      wait_clk(H);
      sda_m = 1'b1;
      wait_clk(H);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
      send_bit(~master_ack, s);
   endtask

   // pointer write, repeated START, read address; returns the three ACKs
   task automatic setup_read(input logic [7:0] ptr, output logic [2:0] acks);
      i2c_start();
      write_byte(8'h18, acks[2]);
      write_byte(ptr, acks[1]);
      i2c_start();
      write_byte(8'h19, acks[0]);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wait_clk(4);
      n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
      n_vec++; if (scl_oe !== 1'b0) begin n_err++; $display("FAIL reset_scl_oe: got %b expected 0", scl_oe); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_vec++; if (reg_ptr !== 8'h00) begin n_err++; $display("FAIL reset_reg_ptr: got %h expected 00", reg_ptr); end
      n_vec++; if (rd_done !== 1'b0) begin n_err++; $display("FAIL reset_rd_done: got %b expected 0", rd_done); end
      reset_n = 1'b1;
      wait_clk(10);
   endtask

   task automatic test_angle_read();
      logic [2:0] acks;
      logic [7:0] d0, d1;
      int rd0, so0, exp_str;
`ifdef A1335_RESP_STRETCH_EN
      exp_str = 64;
`else
      exp_str = 0;
`endif
      device_id = 7'h0C;
      angle = 12'hABC;
      rd0 = rd_done_cnt;
      so0 = scl_oe_cycles;
      setup_read(8'h20, acks);
      read_byte(1'b1, d0);
      read_byte(1'b0, d1);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL angle_busy_before_stop: got %b expected 1", busy); end
      i2c_stop();
      n_vec++; if (acks !== 3'b111) begin n_err++; $display("FAIL angle_acks: got %b expected 111", acks); end
      n_vec++; if (d0 !== 8'h0A) begin n_err++; $display("FAIL angle_hi: got %h expected 0a", d0); end
      n_vec++; if (d1 !== 8'hBC) begin n_err++; $display("FAIL angle_lo: got %h expected bc", d1); end
      n_vec++; if (rd_done_cnt - rd0 !== 2) begin n_err++; $display("FAIL angle_rd_done: got %0d expected 2", rd_done_cnt - rd0); end
      n_vec++; if (reg_ptr !== 8'h22) begin n_err++; $display("FAIL angle_reg_ptr: got %h expected 22", reg_ptr); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL angle_busy_after_stop: got %b expected 0", busy); end
      n_vec++; if (scl_oe_cycles - so0 !== exp_str) begin n_err++; $display("FAIL angle_stretch: got %0d cycles expected %0d", scl_oe_cycles - so0, exp_str); end
   endtask

   task automatic test_status_read();
      logic [2:0] acks;
      logic [31:0] d;
      status = 32'hDEADBEEF;
      setup_read(8'h24, acks);
      read_byte(1'b1, d[31:24]);
      read_byte(1'b1, d[23:16]);
      read_byte(1'b1, d[15:8]);
      read_byte(1'b0, d[7:0]);
      i2c_stop();
      n_vec++; if (acks !== 3'b111) begin n_err++; $display("FAIL status_acks: got %b expected 111", acks); end
      n_vec++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL status_bytes: got %h expected deadbeef", d); end
      n_vec++; if (reg_ptr !== 8'h28) begin n_err++; $display("FAIL status_reg_ptr: got %h expected 28", reg_ptr); end
   endtask

   task automatic test_coherent();
      logic [2:0] acks;
      logic [7:0] d0, d1;
      angle = 12'h123;
      setup_read(8'h20, acks);
      read_byte(1'b1, d0);
      angle = 12'h456;
      read_byte(1'b0, d1);
      i2c_stop();
      n_vec++; if (d0 !== 8'h01) begin n_err++; $display("FAIL coherent_hi: got %h expected 01", d0); end
      n_vec++; if (d1 !== 8'h23) begin n_err++; $display("FAIL coherent_lo: got %h expected 23", d1); end
   endtask

   task automatic test_mismatch();
      logic a0, a1;
      int oe0;
      oe0 = sda_oe_cycles;
      i2c_start();
      write_byte(8'h1A, a0);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mismatch_busy_frame: got %b expected 0", busy); end
      write_byte(8'h55, a1);
      i2c_stop();
      n_vec++; if (a0 !== 1'b0) begin n_err++; $display("FAIL mismatch_addr_ack: got %b expected 0", a0); end
      n_vec++; if (a1 !== 1'b0) begin n_err++; $display("FAIL mismatch_data_ack: got %b expected 0", a1); end
      n_vec++; if (sda_oe_cycles != oe0) begin n_err++; $display("FAIL mismatch_sda_oe: got %0d driven cycles expected 0", sda_oe_cycles - oe0); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mismatch_busy: got %b expected 0", busy); end
      n_vec++; if (reg_ptr !== 8'h22) begin n_err++; $display("FAIL mismatch_reg_ptr: got %h expected 22", reg_ptr); end
   endtask

   task automatic test_wrap_glitch();
      logic a0, a1, a2;
      logic [7:0] d0, d1;
      // glitches on SCL while low, SDA held low: a leaked edge would shift in zeros
      i2c_start();
      for (int g = 0; g < 3; g++) begin
         wait_clk(4);
         scl_m = 1'b1;
         wait_clk(1);
         scl_m = 1'b0;
      end
      write_byte(8'h18, a0);
      write_byte(8'hFF, a1);
      i2c_start();
      write_byte(8'h19, a2);
      read_byte(1'b1, d0);
      read_byte(1'b0, d1);
      i2c_stop();
      n_vec++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL glitch_acks: got %b expected 111", {a0, a1, a2}); end
      n_vec++; if (d0 !== 8'h00) begin n_err++; $display("FAIL wrap_byte0: got %h expected 00", d0); end
      n_vec++; if (d1 !== 8'h00) begin n_err++; $display("FAIL wrap_byte1: got %h expected 00", d1); end
      n_vec++; if (reg_ptr !== 8'h01) begin n_err++; $display("FAIL wrap_reg_ptr: got %h expected 01", reg_ptr); end
   endtask

   task automatic test_reset_mid();
      logic [2:0] acks;
      logic [7:0] d;
      logic s;
      angle = 12'h000;
      setup_read(8'h21, acks);
      for (int i = 0; i < 3; i++) send_bit(1'b1, s);
      wait_clk(Q);
      sda_m = 1'b1;
      wait_clk(H);
      scl_high();
      wait_clk(H / 2);
      n_vec++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_sda_oe: got %b expected 1", sda_oe); end
      reset_n = 1'b0;
      wait_clk(1);
      reset_n = 1'b1;
      n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_sda_oe: got %b expected 0", sda_oe); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      n_vec++; if (reg_ptr !== 8'h00) begin n_err++; $display("FAIL rstmid_reg_ptr: got %h expected 00", reg_ptr); end
      wait_clk(H);
      scl_m = 1'b0;
      wait_clk(H);
      i2c_stop();
      status = 32'h10FF0000;
      setup_read(8'h24, acks);
      read_byte(1'b0, d);
      i2c_stop();
      n_vec++; if (acks !== 3'b111) begin n_err++; $display("FAIL rstmid_after_acks: got %b expected 111", acks); end
      n_vec++; if (d !== 8'h10) begin n_err++; $display("FAIL rstmid_after_data: got %h expected 10", d); end
   endtask

   task automatic test_stop_mid();
      logic [2:0] acks;
      logic [7:0] d;
      logic s;
      int rd0;
      setup_read(8'h24, acks);
      rd0 = rd_done_cnt;
      for (int i = 0; i < 3; i++) send_bit(1'b1, s);
      // 4th bit of 8'h10 is 1, so the target releases SDA and the master can raise it
      wait_clk(Q);
      sda_m = 1'b0;
      wait_clk(H);
      scl_high();
      wait_clk(H);
      sda_m = 1'b1;
      wait_clk(H);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stopmid_busy: got %b expected 0", busy); end
      n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL stopmid_sda_oe: got %b expected 0", sda_oe); end
      n_vec++; if (rd_done_cnt != rd0) begin n_err++; $display("FAIL stopmid_rd_done: got %0d pulses expected 0", rd_done_cnt - rd0); end
      angle = 12'h7E5;
      setup_read(8'h20, acks);
      read_byte(1'b0, d);
      i2c_stop();
      n_vec++; if (acks !== 3'b111) begin n_err++; $display("FAIL stopmid_after_acks: got %b expected 111", acks); end
      n_vec++; if (d !== 8'h07) begin n_err++; $display("FAIL stopmid_after_data: got %h expected 07", d); end
      n_vec++; if (reg_ptr !== 8'h21) begin n_err++; $display("FAIL stopmid_reg_ptr: got %h expected 21", reg_ptr); end
   endtask

   initial begin
      test_reset();
      test_angle_read();
      test_status_read();
      test_coherent();
      test_mismatch();
      test_wrap_glitch();
      test_reset_mid();
      test_stop_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
